// File: rtl/parser_pkg.sv
// Definitions shared between the sequence parser and the payload serializer.
package parser_pkg;

    localparam int REC_BYTES = 37;
    localparam int REC_W     = REC_BYTES * 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/payload_serializer_if.sv
// Record-in / byte-out handshake bundle of the payload serializer.
interface payload_serializer_if #(
    parameter int REC_BYTES = parser_pkg::REC_BYTES
);

    logic [0:REC_BYTES*8-1] dataIn;
    logic                   dataIn_val;
    logic                   dataIn_lost;
    logic                   dataIn_ready;
    logic [7:0]             dataOut;
    logic                   dataOut_val;
    logic                   dataOut_last;
    logic                   dataOut_lost;
    logic                   dataOut_ready;

    // master is the serializer: it owns the record accept and the byte stream
    modport master (
        input  dataIn, dataIn_val, dataIn_lost,
        output dataIn_ready,
        output dataOut, dataOut_val, dataOut_last, dataOut_lost,
        input  dataOut_ready
    );

    modport slave (
        output dataIn, dataIn_val, dataIn_lost,
        input  dataIn_ready,
        input  dataOut, dataOut_val, dataOut_last, dataOut_lost,
        output dataOut_ready
    );

endinterface

// File: rtl/payload_serializer_sat_counter.sv
// Statistics counter with synchronous clear (priority over enable) and a
// build-time choice between saturating at all-ones and wrapping.
module sat_counter #(
    parameter int CNT_W    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !(SATURATE && (&cnt_q))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/payload_serializer.sv
// Turns one parser payload record per handshake into a byte stream with
// last/lost markers, and keeps lost-record and emitted-record statistics.
module payload_serializer #(
    parameter int REC_BYTES = parser_pkg::REC_BYTES,
    parameter int CNT_W     = 16,
    parameter bit DROP_LOST = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_b,
    payload_serializer_if.master io,
    input  logic                 cntClear,
    output logic [CNT_W-1:0]     lostCount,
    output logic [CNT_W-1:0]     recCount
);

    import parser_pkg::*;

    localparam int               IDX_W    = $clog2(REC_BYTES);
    localparam int               HOLD_W   = REC_BYTES * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

    ser_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [0:HOLD_W-1] hold_q, hold_d;
    logic              lost_q, lost_d;

    logic sending;
    logic last_byte;
    logic accept;
    logic xfer;
    logic lost_inc;
    logic rec_inc;

    assign sending   = (state_q == SEND);
    assign last_byte = sending && (idx_q == LAST_IDX);
    assign xfer      = sending && io.dataOut_ready;

    // A new record may load in the same cycle the previous last byte leaves.
    assign io.dataIn_ready = (state_q == IDLE) || (last_byte && io.dataOut_ready);
    assign accept          = io.dataIn_val && io.dataIn_ready;

    assign io.dataOut_val  = sending;
    assign io.dataOut_last = last_byte;
    assign io.dataOut_lost = sending && lost_q;
    assign io.dataOut      = hold_q[{idx_q, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        lost_d  = lost_q;
        if (xfer) begin
            if (last_byte) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        if (accept) begin
            hold_d  = io.dataIn;
            lost_d  = io.dataIn_lost;
            idx_d   = '0;
            state_d = (DROP_LOST && io.dataIn_lost) ? IDLE : SEND;
        end
    end

    assign lost_inc = accept && io.dataIn_lost;
    assign rec_inc  = xfer && last_byte;

    sat_counter #(
        .CNT_W   (CNT_W),
        .SATURATE(1'b1)
    ) u_lost_cnt (
        .clk    (clk),
        .reset_b(reset_b),
        .en_i   (lost_inc),
        .clr_i  (cntClear),
        .cnt_o  (lostCount)
    );

    sat_counter #(
        .CNT_W   (CNT_W),
        .SATURATE(1'b0)
    ) u_rec_cnt (
        .clk    (clk),
        .reset_b(reset_b),
        .en_i   (rec_inc),
        .clr_i  (cntClear),
        .cnt_o  (recCount)
    );

endmodule

// File: doc/payload_serializer.md
Name: payload_serializer

Overview:
- Sits directly downstream of the sequence parser.
- Accepts one 296-bit (37-byte) payload record per handshake, together with its packet-lost flag.
- Emits the record as a byte stream using a valid/ready handshake with a last marker.
- Keeps a saturating lost-packet counter and a wrapping count of emitted records. Can optionally discard records flagged as lost.

Parameters:
- REC_BYTES, 37: bytes per input record; input width is REC_BYTES*8.
- CNT_W, 16: width of both statistics counters.
- DROP_LOST, 0: when 1, records accepted with lost=1 are discarded and produce no bytes.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- dataIn  in  REC_BYTES*8  record, indexed [0:REC_BYTES*8-1]; byte k = dataIn[8k:8k+7]; byte 0 is sent first.
- dataIn_val  in  1  record valid.
- dataIn_lost  in  1  packet-lost flag qualifying dataIn.
- dataIn_ready  out  1  record accept.
- dataOut  out  8  current byte.
- dataOut_val  out  1  byte valid.
- dataOut_last  out  1  final byte of record.
- dataOut_lost  out  1  lost flag of the record being emitted, held on every byte.
- dataOut_ready  in  1  downstream accept.
- cntClear  in  1  synchronous clear of both counters.
- lostCount  out  CNT_W  accepted records with lost=1; saturates at all-ones.
- recCount  out  CNT_W  records whose last byte was transferred; wraps.

Behaviour:
- Reset (async, reset_b=0):
  - state=IDLE, byte index=0, holding register=0, lost latch=0, both counters=0.
  - Outputs: dataOut_val=0, dataOut_last=0, dataOut_lost=0, dataOut=0.
  - A record in flight when reset asserts is discarded; nothing resumes after release.
- States: IDLE, SEND.
- dataIn_ready is combinational: 1 when state==IDLE, or when state==SEND and dataOut_last and dataOut_ready are both 1. This gives zero-bubble back-to-back records.
- Accept (dataIn_val and dataIn_ready):
  - Latch dataIn and dataIn_lost; index <= 0.
  - If dataIn_lost, lostCount increments (saturating). This happens regardless of DROP_LOST.
  - If DROP_LOST==1 and dataIn_lost==1: state <= IDLE, record discarded.
  - Otherwise: state <= SEND.
- SEND:
  - dataOut_val=1; dataOut = held byte[index]; dataOut_last = (index==REC_BYTES-1); dataOut_lost = latched flag.
  - dataOut / dataOut_lost / dataOut_last stay stable while dataOut_val=1 and dataOut_ready=0.
  - On a transfer (val and ready) with last=0: index++.
  - On a transfer with last=1: recCount++ (wrapping). state <= IDLE unless a new record is accepted in the same cycle, in which case the new record is loaded and state stays SEND.
- Latency: first byte is valid the cycle after accept. Sustained rate is one byte per cycle; a record occupies REC_BYTES cycles.
- IDLE: dataOut_val=0; dataOut holds its last value (don't-care).
- cntClear:
  - Both counters become 0 next cycle.
  - Clear wins over a coincident increment.
- Index width is clog2(REC_BYTES). It never exceeds REC_BYTES-1.
- dataIn_val while dataIn_ready=0 is ignored; the upstream must hold the record.

Decomposition:
- Shared package parser_pkg holds REC_BYTES=37, REC_W=296, and the serializer state enum {IDLE, SEND}, all shared with the parser.
- One sub-module: sat_counter (CNT_W, enable, clear, saturate-or-wrap select), instanced twice.

Test Plan:
- Single record: byte k = k (0x00..0x24), lost=0, dataOut_ready=1 → bytes 0x00..0x24 on 37 consecutive cycles starting the cycle after accept; last only on 0x24; recCount=1, lostCount=0.
- Backpressure: toggle dataOut_ready 1/0 every cycle → same 37-byte order, no byte dropped or repeated, outputs stable while stalled, dataIn_ready=0 until the last-byte transfer.
- Back-to-back: records A (all 0xAA) and B (all 0x55) offered continuously, ready held at 1 → 74 bytes in 74 consecutive cycles; B accepted in the cycle 0xAA#37 transfers; recCount=2.
- DROP_LOST=1, one record with lost=1 then one with lost=0 → first produces no bytes, dataIn_ready stays 1, lostCount=1; second emits normally with dataOut_lost=0.
- Saturation and clear: CNT_W=4, 17 lost records with DROP_LOST=0 → lostCount=15, recCount=1 (wrapped from 16). Then cntClear coincident with a lost accept → both counters read 0.
- Reset mid-record: reset_b low after 10 bytes → dataOut_val=0 immediately; after release, state=IDLE, dataIn_ready=1, counters 0, the next record starts at byte 0.
